// File: rtl/multicycle_adder_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_adder_if
// Description : Handshake and data bundle for multicycle_adder.
//               master : drives start/a/b/cin (and sub), observes results.
//               slave  : the adder; observes the request, drives
//                        busy/done/sum/cout.
//               Signals:
//                 start  request to begin an addition
//                 a, b   operands (WIDTH bits)
//                 cin    carry-in
//                 sub    subtract select (only with MULTICYCLE_ADDER_SUB_EN)
//                 busy   addition in progress
//                 done   one-cycle pulse, new result on sum/cout
//                 sum    registered result (WIDTH bits)
//                 cout   registered carry out
//               Optional feature macro: MULTICYCLE_ADDER_SUB_EN
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_adder_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
`ifdef MULTICYCLE_ADDER_SUB_EN
   logic             sub;
`endif
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

`ifdef MULTICYCLE_ADDER_SUB_EN
   modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
   modport master (output start, a, b, cin, input busy, done, sum, cout);
   modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface
`default_nettype wire

// File: rtl/multicycle_adder.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_adder
// Description : Adds two WIDTH-bit operands plus carry-in over WIDTH/CHUNK
//               cycles, CHUNK bits per cycle, behind a start/busy/done
//               handshake. Results are registered and held until the next
//               operation completes.
//               Ports:
//                 clk  clock, rising edge
//                 rst  synchronous active-high reset
//                 bus  multicycle_adder_if.slave (start, a, b, cin, [sub],
//                      busy, done, sum, cout)
//               Parameters:
//                 WIDTH  operand/result width
//                 CHUNK  bits added per cycle (WIDTH multiple of CHUNK)
//               Optional feature macro: MULTICYCLE_ADDER_SUB_EN
//                 adds bus.sub; sub=1 computes A + ~B + 1 (cout=1: no borrow)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_adder #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  wire logic          clk,
   input  wire logic          rst,
   multicycle_adder_if.slave  bus
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam int CSUMW  = CHUNK + 1;
   localparam logic [CW-1:0]    LAST_CHUNK = CW'(NCHUNK - 1);
   localparam logic [WIDTH-1:0] CHUNK_MASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_op_q,  a_op_d;
   logic [WIDTH-1:0] b_op_q,  b_op_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q,   cnt_d;
   logic [WIDTH-1:0] acc_q,   acc_d;
   logic [WIDTH-1:0] sum_q,   sum_d;
   logic             cout_q,  cout_d;

   logic             w_sub;
   logic [31:0]      w_base;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CSUMW-1:0] w_chunk_add;
   logic [WIDTH-1:0] w_acc_next;

`ifdef MULTICYCLE_ADDER_SUB_EN
   assign w_sub = bus.sub;
`else
   assign w_sub = 1'b0;
`endif

   // Chunk k lives at bit offset k*CHUNK; shifts avoid variable part-selects.
   assign w_base      = 32'(cnt_q) * 32'(CHUNK);
   assign w_a_chunk   = CHUNK'(a_op_q >> w_base);
   assign w_b_chunk   = CHUNK'(b_op_q >> w_base);
   assign w_chunk_add = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + CSUMW'(carry_q);
   // Partial result with the current chunk's bits merged into place.
   assign w_acc_next  = (acc_q & ~(CHUNK_MASK << w_base))
                      | (WIDTH'(w_chunk_add[CHUNK-1:0]) << w_base);

   always_comb begin
      state_d = state_q;
      a_op_d  = a_op_q;
      b_op_d  = b_op_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      sum_d   = sum_q;
      cout_d  = cout_q;

      case (state_q)
         IDLE, DONE: begin
            if (bus.start) begin
               // Subtraction folds into addition: invert B, force carry-in.
               a_op_d  = bus.a;
               b_op_d  = w_sub ? ~bus.b : bus.b;
               carry_d = w_sub ? 1'b1 : bus.cin;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // start is deliberately not looked at here.
            acc_d   = w_acc_next;
            carry_d = w_chunk_add[CHUNK];
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST_CHUNK) begin
               sum_d   = w_acc_next;
               cout_d  = w_chunk_add[CHUNK];
               cnt_d   = '0;
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_op_q  <= '0;
         b_op_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_op_q  <= a_op_d;
         b_op_q  <= b_op_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   assign bus.busy = (state_q == RUN);
   assign bus.done = (state_q == DONE);
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_adder
// Description : Self-checking bench for multicycle_adder. One instance with
//               WIDTH=8/CHUNK=2 runs a vector table and multi-cycle corner
//               sequences; a second with WIDTH=8/CHUNK=8 covers the
//               single-cycle case. Subtract cases are included when
//               MULTICYCLE_ADDER_SUB_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_adder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   multicycle_adder_if #(.WIDTH(8)) bus2 ();
   multicycle_adder_if #(.WIDTH(8)) bus8 ();

   multicycle_adder #(.WIDTH(8), .CHUNK(2)) u_dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   multicycle_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8.slave)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t vecs [8];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive a request and step through its accept edge.
   task automatic start_op2(input logic [7:0] a, input logic [7:0] b, input logic cin);
      bus2.start = 1'b1;
      bus2.a     = a;
      bus2.b     = b;
      bus2.cin   = cin;
      step();
      bus2.start = 1'b0;
   endtask

   // Count edges after the accept edge until done; bounded at 20.
   task automatic wait_done2(input int first, output int cyc);
      cyc = first;
      while (bus2.done !== 1'b1 && cyc < 20) begin
         step();
         cyc++;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int  cyc;
      logic seen_done;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0};
      vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
      vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
      vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

      rst        = 1'b1;
      bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;
      bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
`ifdef MULTICYCLE_ADDER_SUB_EN
      bus2.sub = 1'b0;
      bus8.sub = 1'b0;
`endif
      step(); step(); step();
      rst = 1'b0;

      // Reset state
      check("rst_busy", 32'(bus2.busy), 32'd0);
      check("rst_done", 32'(bus2.done), 32'd0);
      check("rst_sum",  32'(bus2.sum),  32'd0);
      check("rst_cout", 32'(bus2.cout), 32'd0);
      step();

      // Vector table
      for (int i = 0; i < 8; i++) begin
         start_op2(vecs[i].a, vecs[i].b, vecs[i].cin);
         check($sformatf("v%0d_busy", i), 32'(bus2.busy), 32'd1);
         wait_done2(0, cyc);
         check($sformatf("v%0d_latency", i), 32'(cyc), 32'd4);
         check($sformatf("v%0d_sum", i),  32'(bus2.sum),  32'(vecs[i].sum));
         check($sformatf("v%0d_cout", i), 32'(bus2.cout), 32'(vecs[i].cout));
         step();
         check($sformatf("v%0d_done_pulse", i), 32'(bus2.done), 32'd0);
         check($sformatf("v%0d_idle", i), 32'(bus2.busy), 32'd0);
      end

      // Back-to-back: start high in DONE goes straight to RUN
      start_op2(8'hFF, 8'h01, 1'b0);
      wait_done2(0, cyc);
      check("b2b1_latency", 32'(cyc), 32'd4);
      check("b2b1_sum",  32'(bus2.sum),  32'h00);
      check("b2b1_cout", 32'(bus2.cout), 32'd1);
      start_op2(8'hFF, 8'hFF, 1'b1);
      check("b2b_no_idle", 32'(bus2.busy), 32'd1);
      check("b2b_sum_hold", 32'(bus2.sum), 32'h00);
      wait_done2(0, cyc);
      check("b2b2_latency", 32'(cyc), 32'd4);
      check("b2b2_sum",  32'(bus2.sum),  32'hFF);
      check("b2b2_cout", 32'(bus2.cout), 32'd1);
      step();

      // start during RUN is ignored
      start_op2(8'h01, 8'h02, 1'b0);
      bus2.start = 1'b1; bus2.a = 8'h80; bus2.b = 8'h80;
      step(); step();
      bus2.start = 1'b0;
      wait_done2(2, cyc);
      check("ign_latency", 32'(cyc), 32'd4);
      check("ign_sum",  32'(bus2.sum),  32'h03);
      check("ign_cout", 32'(bus2.cout), 32'd0);
      step();
      check("ign_single_done", 32'(bus2.done), 32'd0);
      check("ign_busy", 32'(bus2.busy), 32'd0);

      // Reset mid-operation aborts with no done pulse
      start_op2(8'h10, 8'h10, 1'b0);
      step(); step();
      check("abort_busy_before", 32'(bus2.busy), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("abort_busy", 32'(bus2.busy), 32'd0);
      check("abort_done", 32'(bus2.done), 32'd0);
      check("abort_sum",  32'(bus2.sum),  32'h00);
      check("abort_cout", 32'(bus2.cout), 32'd0);
      seen_done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         if (bus2.done === 1'b1) seen_done = 1'b1;
      end
      check("abort_no_done", 32'(seen_done), 32'd0);
      check("abort_sum_hold", 32'(bus2.sum), 32'h00);

      // rst wins over start on the same edge
      bus2.start = 1'b1; bus2.a = 8'h11; bus2.b = 8'h22;
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus2.start = 1'b0;
      check("rst_prio_busy", 32'(bus2.busy), 32'd0);
      step();
      check("rst_prio_still_idle", 32'(bus2.busy), 32'd0);

      // CHUNK = WIDTH: done one edge after accept
      bus8.start = 1'b1; bus8.a = 8'hF0; bus8.b = 8'h0F; bus8.cin = 1'b1;
      step();
      bus8.start = 1'b0;
      check("c8_busy", 32'(bus8.busy), 32'd1);
      check("c8_done_early", 32'(bus8.done), 32'd0);
      step();
      check("c8_done", 32'(bus8.done), 32'd1);
      check("c8_sum",  32'(bus8.sum),  32'h00);
      check("c8_cout", 32'(bus8.cout), 32'd1);
      step();
      check("c8_done_pulse", 32'(bus8.done), 32'd0);

`ifdef MULTICYCLE_ADDER_SUB_EN
      // Subtract: cin ignored, cout=1 means no borrow
      bus2.sub = 1'b1;
      start_op2(8'h10, 8'h20, 1'b1);
      wait_done2(0, cyc);
      check("sub1_sum",  32'(bus2.sum),  32'hF0);
      check("sub1_cout", 32'(bus2.cout), 32'd0);
      step();
      start_op2(8'h20, 8'h10, 1'b0);
      wait_done2(0, cyc);
      check("sub2_sum",  32'(bus2.sum),  32'h10);
      check("sub2_cout", 32'(bus2.cout), 32'd1);
      step();
      bus2.sub = 1'b0;
      start_op2(8'h20, 8'h10, 1'b1);
      wait_done2(0, cyc);
      check("sub0_sum",  32'(bus2.sum),  32'h31);
      check("sub0_cout", 32'(bus2.cout), 32'd0);
      step();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
